// File: rtl/bmem_line_adapter.sv
// rtl/bmem_line_adapter.sv - I/D cache line arbiter and 256-bit to 4x64-bit burst converter (optional BMEM_PERF_CTR_EN counters)
module bmem_line_adapter #(
    parameter int DATA_W = 64,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_read,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [DATA_W-1:0] bmem_wdata,
    input  logic [DATA_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);

    localparam int BEATS = LINE_W / DATA_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  beat_cnt;
    logic              last_grant_i;   // 1: I-cache was granted last, 0: D-cache
    logic              grant_i;        // owner of the transfer in flight
    logic [DATA_W-1:0] beat_buf [BEATS];
    logic [LINE_W-1:0] rd_line;
    logic              i_req;
    logic              d_req;
    logic              take_i;
    logic              take_d;
    logic              last_beat;
    logic              unused_addr_bits;

    // Line offsets never reach the burst port.
    assign unused_addr_bits = ^{icache_addr[OFF_W-1:0], dcache_addr[OFF_W-1:0]};

    // Round-robin grant: a lone requester wins, otherwise whoever did not win last time.
    always_comb begin
        i_req     = icache_read;
        d_req     = dcache_read | dcache_write;
        take_i    = i_req & (~d_req | ~last_grant_i);
        take_d    = d_req & ~take_i;
        last_beat = (beat_cnt == CNT_W'(BEATS - 1));
    end

    // Completed line: buffered beats below, the arriving final beat on top.
    always_comb begin
        rd_line = '0;
        for (int k = 0; k < BEATS - 1; k++) begin
            rd_line[k*DATA_W +: DATA_W] = beat_buf[k];
        end
        rd_line[LINE_W-1 -: DATA_W] = bmem_rdata;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and burst/response strobes; strobes derive from state only.
    always_comb begin
        state_nxt   = state;
        bmem_read   = 1'b0;
        bmem_write  = 1'b0;
        bmem_wdata  = '0;
        icache_resp = 1'b0;
        dcache_resp = 1'b0;
        case (state)
            IDLE: begin
                if (take_i) begin
                    state_nxt = RD_REQ;
                end else if (take_d) begin
                    state_nxt = dcache_write ? WR_DATA : RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                if (bmem_resp && last_beat) begin
                    state_nxt = DONE;
                end
            end
            WR_DATA: begin
                bmem_write = 1'b1;
                bmem_wdata = beat_buf[beat_cnt];
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                icache_resp = grant_i;
                dcache_resp = ~grant_i;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping, address/writeback capture, beat collection and line delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt     <= '0;
            last_grant_i <= 1'b0;
            grant_i      <= 1'b0;
            bmem_addr    <= '0;
            icache_rdata <= '0;
            dcache_rdata <= '0;
            for (int k = 0; k < BEATS; k++) begin
                beat_buf[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (take_i || take_d) begin
                        grant_i      <= take_i;
                        last_grant_i <= take_i;
                        bmem_addr    <= take_i ? {icache_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                                               : {dcache_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                    // The writeback line is captured so an early request drop cannot corrupt it.
                    if (take_d && dcache_write) begin
                        for (int k = 0; k < BEATS; k++) begin
                            beat_buf[k] <= dcache_wdata[k*DATA_W +: DATA_W];
                        end
                    end
                end
                RD_DATA: begin
                    if (bmem_resp) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            if (grant_i) begin
                                icache_rdata <= rd_line;
                            end else begin
                                dcache_rdata <= rd_line;
                            end
                        end else begin
                            beat_buf[beat_cnt] <= bmem_rdata;
                            beat_cnt           <= beat_cnt + 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                end
                default: begin
                    beat_cnt <= beat_cnt;
                end
            endcase
        end
    end

`ifdef BMEM_PERF_CTR_EN
    logic [31:0] rd_burst_count;
    logic [31:0] wr_burst_count;
    logic [31:0] contention_count;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating burst and contention counters, sampled at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_burst_count   <= '0;
            wr_burst_count   <= '0;
            contention_count <= '0;
        end else if (state == IDLE) begin
            if (i_req && d_req) begin
                contention_count <= sat_inc(contention_count);
            end
            if (take_i || (take_d && !dcache_write)) begin
                rd_burst_count <= sat_inc(rd_burst_count);
            end
            if (take_d && dcache_write) begin
                wr_burst_count <= sat_inc(wr_burst_count);
            end
        end
    end
`else
    // Performance counters are not built.
`endif

    // A simultaneous D read and write is a client protocol error; the write is served.
    a_no_dcache_rw: assert property (@(posedge clk) disable iff (rst) !(dcache_read && dcache_write));

endmodule
